// File: rtl/hs_src_fifo.sv
// hs_src_fifo: source-domain FIFO that feeds words one at a time into sync_handshake.
// Launches are paced on sync_busy, so upstream logic only has to respect full.
module hs_src_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_LOG2   = 3,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                  clk_source,
    input  logic                  rst_source,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  err_timeout,
    output logic                  sig_pulse_source,
    output logic [DATA_WIDTH-1:0] sig_data_source,
    input  logic                  sync_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [7:0]            wait_cnt, wait_cnt_next;
    logic                  push, pop, empty, timeout_hit;

    // full is judged on the registered count, so a write while full is lost even if a pop happens
    assign full  = (count == DEPTH_COUNT);
    assign empty = (count == '0);
    assign push  = wr_en && !full;

    always_ff @(posedge clk_source) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_source) begin
        if (rst_source) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_source) begin
        if (rst_source) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A launch pops the head immediately; a word that times out is simply lost
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        pop           = 1'b0;
        timeout_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !sync_busy) begin
                    pop           = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (sync_busy) begin
                    state_next = WAIT_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                    if (wait_cnt_next >= TIMEOUT_LIMIT) begin
                        timeout_hit = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!sync_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_source) begin
        if (rst_source) begin
            wait_cnt         <= '0;
            sig_pulse_source <= 1'b0;
            sig_data_source  <= '0;
            err_timeout      <= 1'b0;
        end else begin
            wait_cnt         <= wait_cnt_next;
            sig_pulse_source <= pop;
            if (pop) begin
                sig_data_source <= mem[rd_ptr];
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_src_fifo.sv
// tb_hs_src_fifo: drives hs_src_fifo with directed and random traffic against a
// queue-based reference of the feeder and a simple sync_handshake busy responder.
module tb_hs_src_fifo;
    localparam int DW    = 8;
    localparam int DL2   = 3;
    localparam int TO    = 15;
    localparam int DEPTH = 8;

    localparam int BM_NORMAL = 0;
    localparam int BM_HIGH   = 1;
    localparam int BM_LOW    = 2;
    localparam int BM_RAND   = 3;

    localparam int P_IDLE = 0;
    localparam int P_WB   = 1;
    localparam int P_WD   = 2;

    logic          clk_source = 1'b0;
    logic          rst_source;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [DL2:0]  count;
    logic          overflow;
    logic          err_timeout;
    logic          sig_pulse_source;
    logic [DW-1:0] sig_data_source;
    logic          sync_busy;

    hs_src_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH_LOG2  (DL2),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk_source      (clk_source),
        .rst_source      (rst_source),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .count           (count),
        .overflow        (overflow),
        .err_timeout     (err_timeout),
        .sig_pulse_source(sig_pulse_source),
        .sig_data_source (sig_data_source),
        .sync_busy       (sync_busy)
    );

    always #5 clk_source = ~clk_source;

    int testsRun;
    int testsFailed;
    int cyc;

    logic [DW-1:0] mQ[$];
    int            mPhase;
    int            mWait;
    logic          expPulse;
    logic [DW-1:0] expData;
    logic          expOverflow;
    logic          expErr;

    int busyMode;
    int riseDelay;
    int holdLen;
    int hsRise;
    int hsHold;
    bit hsActive;

    logic [DW-1:0] rxLog[$];
    int            pulseCyc[$];
    int            firstErrCyc;
    int            writeCyc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pickRx(input int idx);
        if (idx < rxLog.size()) return {24'd0, rxLog[idx]};
        return 'x;
    endfunction

    function automatic int pickCyc(input int idx);
        if (idx < pulseCyc.size()) return pulseCyc[idx];
        return -1000;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mPhase      = P_IDLE;
        mWait       = 0;
        expPulse    = 1'b0;
        expData     = '0;
        expOverflow = 1'b0;
        expErr      = 1'b0;
    endtask

    // Reference: queue of stored words plus the launch/wait/done protocol phase
    task automatic modelStep(input logic wr, input logic [DW-1:0] d, input logic busy, input logic rst);
        bit launch;
        bit accept;
        if (rst) begin
            modelReset();
            return;
        end
        launch   = (mPhase == P_IDLE) && (mQ.size() > 0) && !busy;
        accept   = wr && (mQ.size() < DEPTH);
        expPulse = launch;
        if (wr && !accept) expOverflow = 1'b1;
        case (mPhase)
            P_IDLE: begin
                if (launch) begin
                    expData = mQ.pop_front();
                    mWait   = 0;
                    mPhase  = P_WB;
                end
            end
            P_WB: begin
                if (busy) begin
                    mPhase = P_WD;
                end else begin
                    mWait++;
                    if (mWait == TO) begin
                        expErr = 1'b1;
                        mPhase = P_IDLE;
                    end
                end
            end
            default: begin
                if (!busy) mPhase = P_IDLE;
            end
        endcase
        if (accept) mQ.push_back(d);
    endtask

    task automatic setMode(input int m);
        busyMode = m;
        hsActive = 1'b0;
        hsRise   = 0;
        hsHold   = (sync_busy === 1'b1) ? 1 : 0;
    endtask

    // Handshake responder: busy rises riseDelay cycles after a pulse and holds holdLen cycles
    task automatic driveBusy();
        case (busyMode)
            BM_HIGH: sync_busy = 1'b1;
            BM_LOW:  sync_busy = 1'b0;
            BM_RAND: sync_busy = 1'($urandom_range(0, 1));
            default: begin
                if (expPulse) begin
                    hsActive = 1'b1;
                    hsRise   = riseDelay;
                end
                if (hsActive) begin
                    if (hsRise == 0) begin
                        sync_busy = 1'b1;
                        hsActive  = 1'b0;
                        hsHold    = holdLen;
                    end else begin
                        hsRise--;
                    end
                end else if (hsHold > 0) begin
                    hsHold--;
                    if (hsHold == 0) sync_busy = 1'b0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic rst);
        checkOutput("pulse", sig_pulse_source, expPulse);
        checkOutput("data", sig_data_source, expData);
        checkOutput("count", count, mQ.size());
        checkOutput("full", full, mQ.size() == DEPTH);
        checkOutput("overflow", overflow, expOverflow);
        checkOutput("errTimeout", err_timeout, expErr);
        if (sig_pulse_source === 1'b1) begin
            rxLog.push_back(sig_data_source);
            pulseCyc.push_back(cyc);
        end
        if (err_timeout === 1'b1 && firstErrCyc < 0) firstErrCyc = cyc;
        driveBusy();
        wr_en      = wr;
        wr_data    = d;
        rst_source = rst;
        if (wr) writeCyc = cyc;
        modelStep(wr, d, sync_busy, rst);
        @(posedge clk_source);
        @(negedge clk_source);
        cyc++;
    endtask

    task automatic drain(input int cap);
        int n = 0;
        while ((mQ.size() != 0 || mPhase != P_IDLE || sync_busy) && n < cap) begin
            applyStimulus(1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("drainBound", n < cap, 1);
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic compareLog(input string tag, input logic [DW-1:0] expQ[$]);
        checkOutput({tag, "Len"}, rxLog.size(), expQ.size());
        foreach (expQ[i]) checkOutput(tag, pickRx(i), {24'd0, expQ[i]});
    endtask

    task automatic clearLogs();
        rxLog.delete();
        pulseCyc.delete();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] expQ[$];
        int n;
        testsRun    = 0;
        testsFailed = 0;
        cyc         = 0;
        firstErrCyc = -1;
        writeCyc    = 0;
        rst_source  = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        sync_busy   = 1'b0;
        riseDelay   = 1;
        holdLen     = 6;
        setMode(BM_NORMAL);
        modelReset();
        repeat (2) @(posedge clk_source);
        @(negedge clk_source);

        // Single word with busy rising one cycle after the pulse for six cycles
        clearLogs();
        applyStimulus(1'b1, 8'hA5, 1'b0);
        drain(100);
        checkOutput("singleLen", rxLog.size(), 1);
        checkOutput("singleData", pickRx(0), 32'hA5);
        checkOutput("singleLatency", pickCyc(0) - writeCyc, 2);

        // Burst of eight while the handshake is busy, then drain in order
        clearLogs();
        setMode(BM_HIGH);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("burstFull", full, 1);
        checkOutput("burstOverflow", overflow, 0);
        setMode(BM_NORMAL);
        riseDelay = $urandom_range(0, 2);
        holdLen   = $urandom_range(1, 3);
        drain(400);
        expQ.delete();
        for (int i = 1; i <= 8; i++) expQ.push_back(8'(i));
        compareLog("burstOrder", expQ);

        // Overflow: write while full is dropped, including when a pop happens the same cycle
        clearLogs();
        expQ.delete();
        setMode(BM_HIGH);
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(8'($urandom_range(0, 254)));
            applyStimulus(1'b1, expQ[i], 1'b0);
        end
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("ovfFlag", overflow, 1);
        checkOutput("ovfCount", count, 8);
        setMode(BM_NORMAL);
        riseDelay = 1;
        holdLen   = 2;
        applyStimulus(1'b1, 8'hEE, 1'b0);
        drain(400);
        checkOutput("ovfSticky", overflow, 1);
        compareLog("ovfDrain", expQ);

        // Pointer wrap: twenty single-word round trips
        clearLogs();
        expQ.delete();
        for (int i = 0; i < 20; i++) begin
            riseDelay = $urandom_range(0, 3);
            holdLen   = $urandom_range(1, 4);
            expQ.push_back(8'(8'h10 + i));
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
            drain(100);
        end
        compareLog("wrapOrder", expQ);

        // Reset while waiting for busy to drop with three words queued
        setMode(BM_NORMAL);
        riseDelay = 0;
        holdLen   = 20;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
        n = 0;
        while (mPhase != P_WD && n < 30) begin
            applyStimulus(1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("queuedBeforeReset", count, 3);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rstCount", count, 0);
        checkOutput("rstPulse", sig_pulse_source, 0);
        checkOutput("rstData", sig_data_source, 0);
        setMode(BM_LOW);
        clearLogs();
        repeat (10) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("noLaunchAfterReset", rxLog.size(), 0);
        setMode(BM_NORMAL);
        riseDelay = 1;
        holdLen   = 2;
        applyStimulus(1'b1, 8'h77, 1'b0);
        drain(100);
        checkOutput("postResetLen", rxLog.size(), 1);
        checkOutput("postResetData", pickRx(0), 32'h77);

        // Timeout: busy never rises, so each word is abandoned after TO cycles
        clearLogs();
        setMode(BM_LOW);
        firstErrCyc = -1;
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        n = 0;
        while (firstErrCyc < 0 && n < 60) begin
            applyStimulus(1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("timeoutSeen", firstErrCyc >= 0, 1);
        checkOutput("timeoutLatency", firstErrCyc - pickCyc(0), TO);
        repeat (3) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("nextLaunchedLen", rxLog.size(), 2);
        checkOutput("nextLaunchedData", pickRx(1), 32'h5A);
        checkOutput("nextLaunchGap", pickCyc(1) - firstErrCyc, 1);
        drain(100);

        // Random traffic under different busy behaviours with occasional resets
        for (int seg = 0; seg < 8; seg++) begin
            setMode(($urandom_range(0, 1) == 1) ? BM_NORMAL : BM_RAND);
            riseDelay = $urandom_range(0, 3);
            holdLen   = $urandom_range(1, 4);
            for (int i = 0; i < 100; i++) begin
                applyStimulus($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 199) == 0);
            end
        end
        setMode(BM_NORMAL);
        drain(600);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
